// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: valid/ready word stream with last marker
//   out_valid  word present (master -> slave)
//   out_data   word payload (master -> slave)
//   out_last   final word of a transfer (master -> slave)
//   out_ready  consumer accepts the word (slave -> master)
interface ram_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    modport master(output out_valid, out_data, out_last, input out_ready);
    modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a RAM async read port from base for len words onto a valid/ready stream
//   clk, rst          clock, asynchronous active-high reset
//   start, base, len  command strobe, first address, word count (sampled while idle)
//   busy, done, err   transfer active, completion pulse, rejected-command pulse
//   rd_addr, rd_data  RAM async read port
//   stream            master side of the output stream (out_valid/out_ready/out_data/out_last)
// Macro RAM_STREAM_READER_WRAP_EN: addresses wrap modulo DEPTH and no command is rejected.
module ram_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] base,
    input  logic [DEPTH_LOG:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DEPTH_LOG-1:0] rd_addr,
    input  logic [WIDTH-1:0]     rd_data,
    ram_stream_reader_if.master  stream
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state;
    logic [DEPTH_LOG-1:0] addr;
    logic [DEPTH_LOG:0]   rem;
    logic                 bad;
    logic                 load;
`ifdef RAM_STREAM_READER_WRAP_EN
    assign bad = 1'b0;
`else
    localparam logic [DEPTH_LOG+1:0] LIMIT = (DEPTH_LOG+2)'(DEPTH);
    assign bad = ({2'b0, base} + {1'b0, len}) > LIMIT;
`endif
    // the output register refills whenever it is empty or being drained this cycle
    assign load    = (rem != '0) && (!stream.out_valid || stream.out_ready);
    assign rd_addr = addr;
    assign busy    = state == RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            addr             <= '0;
            rem              <= '0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_last  <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (len == '0) begin
                        done <= 1'b1;
                    end else if (bad) begin
                        err <= 1'b1;
                    end else begin
                        addr  <= base;
                        rem   <= len;
                        state <= RUN;
                    end
                end
            end else if (load) begin
                stream.out_data  <= rd_data;
                stream.out_valid <= 1'b1;
                stream.out_last  <= rem == (DEPTH_LOG+1)'(1);
                addr             <= addr + DEPTH_LOG'(1);
                rem              <= rem - (DEPTH_LOG+1)'(1);
            end else if (stream.out_valid && stream.out_ready) begin
                stream.out_valid <= 1'b0;
                stream.out_last  <= 1'b0;
                if (stream.out_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: table-driven check of ram_stream_reader against RAM[i]=0xA0+i
module tb_ram_stream_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base = '0;
    logic [4:0] len = '0;
    logic       busy, done, err;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] mem [16];
    int         cmp = 0;
    int         mis = 0;

    ram_stream_reader_if #(.WIDTH(8)) stream();

    ram_stream_reader #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data), .stream(stream)
    );

    always #5 clk = ~clk;
    assign rd_data = mem[rd_addr];

    // mode: 0 ready always high, 1 ready toggles, 2 ready high plus a start pulse while busy
    typedef struct {
        logic [3:0] base;
        logic [4:0] len;
        int         mode;
        bit         exp_err;
        bit         exp_done;
        logic [3:0] first;
        int         n;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        int         c, k;
        logic       held_v;
        logic [7:0] held_d, exp;
        start = 1'b1;
        base = v.base;
        len = v.len;
        stream.out_ready = 1'b1;
        tick();
        start = 1'b0;
        if (v.n == 0) begin
            chk("err_c1", err, v.exp_err);
            chk("done_c1", done, v.exp_done);
            chk("busy_c1", busy, 0);
            chk("valid_c1", stream.out_valid, 0);
            tick();
            chk("err_c2", err, 0);
            chk("done_c2", done, 0);
            chk("busy_c2", busy, 0);
            chk("valid_c2", stream.out_valid, 0);
            return;
        end
        chk("busy_c1", busy, 1);
        chk("rdaddr_c1", rd_addr, v.base);
        chk("valid_c1", stream.out_valid, 0);
        chk("err_c1", err, 0);
        chk("done_c1", done, 0);
        c = 1;
        k = 0;
        held_v = 1'b0;
        held_d = '0;
        while (k < v.n && c < 80) begin
            tick();
            c++;
            stream.out_ready = (v.mode == 1) ? (c % 2 == 0) : 1'b1;
            if (v.mode == 2) begin
                start = (c == 3);
                base = 4'd9;
                len = 5'd3;
            end
            chk("busy_run", busy, 1);
            if (held_v) chk("hold_data", stream.out_data, held_d);
            held_v = stream.out_valid && !stream.out_ready;
            held_d = stream.out_data;
            if (stream.out_valid && stream.out_ready) begin
                exp = {4'hA, v.first + 4'(k)};
                chk("data", stream.out_data, exp);
                chk("last", stream.out_last, k == v.n - 1);
                if (v.mode != 1) chk("hs_cycle", c, 2 + k);
                k++;
            end
        end
        start = 1'b0;
        chk("words_received", k, v.n);
        tick();
        chk("done_end", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", stream.out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        stream.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", stream.out_valid, 0);
        chk("rst_last", stream.out_last, 0);
        chk("rst_data", stream.out_data, 0);
        chk("rst_rdaddr", rd_addr, 0);
        rst = 1'b0;
        tick();

        vecs[0] = '{4'd2, 5'd4, 0, 1'b0, 1'b0, 4'h2, 4};
        vecs[1] = '{4'd2, 5'd4, 1, 1'b0, 1'b0, 4'h2, 4};
        vecs[2] = '{4'd5, 5'd0, 0, 1'b0, 1'b1, 4'h0, 0};
        vecs[4] = '{4'd2, 5'd4, 2, 1'b0, 1'b0, 4'h2, 4};
        vecs[5] = '{4'd0, 5'd16, 0, 1'b0, 1'b0, 4'h0, 16};
        vecs[6] = '{4'd15, 5'd1, 0, 1'b0, 1'b0, 4'hF, 1};
        vecs[7] = '{4'd12, 5'd4, 0, 1'b0, 1'b0, 4'hC, 4};
`ifdef RAM_STREAM_READER_WRAP_EN
        vecs[3] = '{4'd14, 5'd4, 0, 1'b0, 1'b0, 4'hE, 4};
        vecs[8] = '{4'd13, 5'd4, 0, 1'b0, 1'b0, 4'hD, 4};
`else
        vecs[3] = '{4'd14, 5'd4, 0, 1'b1, 1'b0, 4'h0, 0};
        vecs[8] = '{4'd13, 5'd4, 0, 1'b1, 1'b0, 4'h0, 0};
`endif
        for (int i = 0; i < 9; i++) run(vecs[i]);

        // abort a 6-word transfer after two words have been handed over
        start = 1'b1;
        base = 4'd0;
        len = 5'd6;
        stream.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_w0", stream.out_data, 8'hA0);
        tick();
        chk("pre_rst_w1", stream.out_data, 8'hA1);
        tick();
        chk("pre_rst_valid", stream.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", stream.out_valid, 0);
        chk("mid_rst_rdaddr", rd_addr, 0);
        chk("mid_rst_last", stream.out_last, 0);
        #1 rst = 1'b0;
        tick();
        run('{4'd0, 5'd2, 0, 1'b0, 1'b0, 4'h0, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
